// File: rtl/vanilla_sb_profiler_pkg.sv
// Shared types for the scoreboard stall profiler: cause encoding, scoreboard
// entry layouts as exported by the core's scoreboard tracker, and the helpers
// that turn scoreboard entries into per-cause hit bits.
package vanilla_sb_profiler_pkg;

    localparam int RV32_reg_addr_width_gp = 5;
    localparam int RV32_reg_els_gp        = 32;
    localparam int num_stall_cat_gp       = 11;

    // Cause codes double as counter indices; CAT_NONE marks "not counting".
    typedef enum logic [3:0] {
        CAT_IDIV        = 4'd0,
        CAT_I_DRAM_LD   = 4'd1,
        CAT_I_DRAM_AMO  = 4'd2,
        CAT_I_GLOBAL_LD = 4'd3,
        CAT_I_GROUP_LD  = 4'd4,
        CAT_I_GROUP_AMO = 4'd5,
        CAT_FDIV_FSQRT  = 4'd6,
        CAT_F_DRAM_LD   = 4'd7,
        CAT_F_GLOBAL_LD = 4'd8,
        CAT_F_GROUP_LD  = 4'd9,
        CAT_OTHER       = 4'd10,
        CAT_NONE        = 4'hF
    } stall_cat_e;

    // Integer scoreboard entry: which kind of long-latency op owns the register.
    typedef struct packed {
        logic idiv;
        logic remote_dram_load;
        logic remote_dram_amo;
        logic remote_global_load;
        logic remote_group_load;
        logic remote_group_amo;
    } vanilla_isb_info_s;

    // Float scoreboard entry.
    typedef struct packed {
        logic fdiv_fsqrt;
        logic remote_dram_load;
        logic remote_global_load;
        logic remote_group_load;
    } vanilla_fsb_info_s;

    typedef enum logic {
        SNAP_IDLE = 1'b0,
        SNAP_HOLD = 1'b1
    } snap_state_e;

    // Integer entry as hit bits, bit k = cause k (CAT_IDIV..CAT_I_GROUP_AMO).
    function automatic logic [5:0] isb_cause_bits(input vanilla_isb_info_s s);
        return {s.remote_group_amo, s.remote_group_load, s.remote_global_load,
                s.remote_dram_amo, s.remote_dram_load, s.idiv};
    endfunction

    // Float entry as hit bits, bit k = cause 6+k (CAT_FDIV_FSQRT..CAT_F_GROUP_LD).
    function automatic logic [3:0] fsb_cause_bits(input vanilla_fsb_info_s s);
        return {s.remote_group_load, s.remote_global_load, s.remote_dram_load, s.fdiv_fsqrt};
    endfunction

    // Lowest set hit bit wins; a stall with no scoreboard hit is CAT_OTHER.
    function automatic stall_cat_e pick_cat(input logic [num_stall_cat_gp-2:0] hits);
        stall_cat_e cat;
        cat = CAT_OTHER;
        for (int k = num_stall_cat_gp - 2; k >= 0; k--) begin
            if (hits[k]) cat = stall_cat_e'(k[3:0]);
        end
        return cat;
    endfunction

endpackage

// File: rtl/vanilla_sat_counter.sv
// Saturating up-counter with a synchronous clear that can optionally restart
// the count at one, so an increment coinciding with a clear is not lost.
module vanilla_sat_counter #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               load_one_i,
    input  logic               inc_i,
    output logic [width_p-1:0] count_o
);

    // Count register: clear has priority, otherwise increment until all-ones.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= {{(width_p-1){1'b0}}, load_one_i};
        end else if (inc_i && !(&count_o)) begin
            count_o <= count_o + 1'b1;
        end
    end

endmodule

// File: rtl/vanilla_sb_stall_profiler.sv
// Attributes each dependency-stall cycle of the ID stage to one scoreboard
// cause, keeps a saturating cycle count per cause, and exposes the counters
// through a one-deep ready/valid snapshot port.
module vanilla_sb_stall_profiler
    import vanilla_sb_profiler_pkg::*;
#(
    parameter int ctr_width_p       = 32,
    parameter bit clear_on_snap_p   = 1'b1,
    parameter int reg_addr_width_lp = RV32_reg_addr_width_gp
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    stall_depend_i,
    input  logic                                    stall_all_i,
    input  logic [reg_addr_width_lp-1:0]            id_rs1_i,
    input  logic [reg_addr_width_lp-1:0]            id_rs2_i,
    input  logic [reg_addr_width_lp-1:0]            id_rs3_i,
    input  logic [reg_addr_width_lp-1:0]            id_rd_i,
    input  logic                                    id_read_rs1_i,
    input  logic                                    id_read_rs2_i,
    input  logic                                    id_read_frs1_i,
    input  logic                                    id_read_frs2_i,
    input  logic                                    id_read_frs3_i,
    input  logic                                    id_write_rd_i,
    input  logic                                    id_write_frd_i,
    input  vanilla_isb_info_s                       int_sb_i   [RV32_reg_els_gp],
    input  vanilla_fsb_info_s                       float_sb_i [RV32_reg_els_gp],
    input  logic                                    snap_v_i,
    output logic                                    snap_ready_o,
    output logic                                    snap_v_o,
    output logic [num_stall_cat_gp*ctr_width_p-1:0] snap_data_o,
    input  logic                                    snap_yumi_i,
    output logic [3:0]                              cur_cat_o
);

    logic [5:0]                              int_hit;
    logic [3:0]                              float_hit;
    logic                                    cnt_en;
    stall_cat_e                              cat;
    snap_state_e                             state_q, state_n;
    logic                                    capture;
    logic                                    clear_all;
    logic [num_stall_cat_gp*ctr_width_p-1:0] live_cnt;
    logic [num_stall_cat_gp*ctr_width_p-1:0] shadow_q;

    // Gather scoreboard hits over the operands the ID instruction actually uses;
    // x0 is never written so its integer entry is ignored.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        int_hit   = '0;
        float_hit = '0;
        if (id_read_rs1_i && (id_rs1_i != '0)) int_hit = int_hit | isb_cause_bits(int_sb_i[id_rs1_i]);
        if (id_read_rs2_i && (id_rs2_i != '0)) int_hit = int_hit | isb_cause_bits(int_sb_i[id_rs2_i]);
        if (id_write_rd_i && (id_rd_i  != '0)) int_hit = int_hit | isb_cause_bits(int_sb_i[id_rd_i]);
        if (id_read_frs1_i) float_hit = float_hit | fsb_cause_bits(float_sb_i[id_rs1_i]);
        if (id_read_frs2_i) float_hit = float_hit | fsb_cause_bits(float_sb_i[id_rs2_i]);
        if (id_read_frs3_i) float_hit = float_hit | fsb_cause_bits(float_sb_i[id_rs3_i]);
        if (id_write_frd_i) float_hit = float_hit | fsb_cause_bits(float_sb_i[id_rd_i]);
    end

    assign cnt_en = stall_depend_i & ~stall_all_i;
    assign cat    = cnt_en ? pick_cat({float_hit, int_hit}) : CAT_NONE;

    // Registered view of the cause attributed in the previous cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cur_cat_o <= CAT_NONE;
        else         cur_cat_o <= cat;
    end

    // Snapshot state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= SNAP_IDLE;
        else         state_q <= state_n;
    end

    // Snapshot next state: accept in IDLE, hold until the consumer takes it;
    // requests arriving during HOLD are dropped.
    always_comb begin
        state_n = state_q;
        capture = 1'b0;
        case (state_q)
            SNAP_IDLE: begin
                if (snap_v_i) begin
                    capture = 1'b1;
                    state_n = SNAP_HOLD;
                end
            end
            SNAP_HOLD: begin
                if (snap_yumi_i) state_n = SNAP_IDLE;
            end
        endcase
    end

    assign snap_ready_o = (state_q == SNAP_IDLE);
    assign snap_v_o     = (state_q == SNAP_HOLD);
    assign clear_all    = capture & clear_on_snap_p;

    // One counter per cause; a clear in a counting cycle restarts the
    // attributed counter at one so that cycle is still accounted for.
    for (genvar k = 0; k < num_stall_cat_gp; k++) begin : g_ctr
        localparam logic [3:0] cat_lp = 4'(k);
        logic inc;
        assign inc = cnt_en & (cat == cat_lp);

        vanilla_sat_counter #(
            .width_p (ctr_width_p)
        ) u_ctr (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .clear_i    (clear_all),
            .load_one_i (inc),
            .inc_i      (inc),
            .count_o    (live_cnt[k*ctr_width_p +: ctr_width_p])
        );
    end

    // Shadow copy taken on acceptance; holds pre-increment counter values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)      shadow_q <= '0;
        else if (capture) shadow_q <= live_cnt;
    end

    assign snap_data_o = shadow_q;

endmodule

// File: tb/tb_vanilla_sb_stall_profiler.sv
// Bench for vanilla_sb_stall_profiler: two instances (32-bit clearing, 4-bit
// non-clearing) share one stimulus stream; a cycle model predicts counters and
// queues expected snapshots at request acceptance, compared while presented.
module tb_vanilla_sb_stall_profiler;
    import vanilla_sb_profiler_pkg::*;

    localparam int N  = num_stall_cat_gp;
    localparam int W0 = 32;
    localparam int W1 = 4;
    localparam int CW = N * W0;
    typedef logic [CW-1:0] cmp_t;

    logic clk;
    logic reset_i;
    logic stall_depend, stall_all;
    logic [4:0] rs1, rs2, rs3, rd;
    logic read_rs1, read_rs2, read_frs1, read_frs2, read_frs3, write_rd, write_frd;
    vanilla_isb_info_s int_sb   [RV32_reg_els_gp];
    vanilla_fsb_info_s float_sb [RV32_reg_els_gp];
    logic snap_v, snap_yumi;

    logic            ready0, valid0, ready1, valid1;
    logic [N*W0-1:0] data0;
    logic [N*W1-1:0] data1;
    logic [3:0]      cat0, cat1;

    int n_vec, n_err;

    // Model state
    logic [W0-1:0]   m0 [N];
    logic [W1-1:0]   m1 [N];
    logic            m_hold;
    logic [3:0]      m_cat;
    logic [N*W0-1:0] q0 [$];
    logic [N*W1-1:0] q1 [$];
    logic [N*W0-1:0] last0;
    logic [N*W1-1:0] last1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vanilla_sb_stall_profiler #(.ctr_width_p(W0), .clear_on_snap_p(1'b1)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .stall_depend_i(stall_depend), .stall_all_i(stall_all),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs3_i(rs3), .id_rd_i(rd),
        .id_read_rs1_i(read_rs1), .id_read_rs2_i(read_rs2),
        .id_read_frs1_i(read_frs1), .id_read_frs2_i(read_frs2), .id_read_frs3_i(read_frs3),
        .id_write_rd_i(write_rd), .id_write_frd_i(write_frd),
        .int_sb_i(int_sb), .float_sb_i(float_sb),
        .snap_v_i(snap_v), .snap_ready_o(ready0), .snap_v_o(valid0), .snap_data_o(data0),
        .snap_yumi_i(snap_yumi), .cur_cat_o(cat0));

    vanilla_sb_stall_profiler #(.ctr_width_p(W1), .clear_on_snap_p(1'b0)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .stall_depend_i(stall_depend), .stall_all_i(stall_all),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs3_i(rs3), .id_rd_i(rd),
        .id_read_rs1_i(read_rs1), .id_read_rs2_i(read_rs2),
        .id_read_frs1_i(read_frs1), .id_read_frs2_i(read_frs2), .id_read_frs3_i(read_frs3),
        .id_write_rd_i(write_rd), .id_write_frd_i(write_frd),
        .int_sb_i(int_sb), .float_sb_i(float_sb),
        .snap_v_i(snap_v), .snap_ready_o(ready1), .snap_v_o(valid1), .snap_data_o(data1),
        .snap_yumi_i(snap_yumi), .cur_cat_o(cat1));

    task automatic check(input string tag, input cmp_t got, input cmp_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference attribution written as an explicit priority cascade.
    function automatic logic [3:0] ref_cat();
        logic [5:0] ih;
        logic [3:0] fh;
        logic [4:0] iidx [3];
        logic       iuse [3];
        logic [4:0] fidx [4];
        logic       fuse [4];
        if (!stall_depend || stall_all) return 4'hF;
        ih = '0;
        fh = '0;
        iidx = '{rs1, rs2, rd};
        iuse = '{read_rs1, read_rs2, write_rd};
        fidx = '{rs1, rs2, rs3, rd};
        fuse = '{read_frs1, read_frs2, read_frs3, write_frd};
        for (int i = 0; i < 3; i++) begin
            if (iuse[i] && iidx[i] != 5'd0) begin
                ih[0] = ih[0] | int_sb[iidx[i]].idiv;
                ih[1] = ih[1] | int_sb[iidx[i]].remote_dram_load;
                ih[2] = ih[2] | int_sb[iidx[i]].remote_dram_amo;
                ih[3] = ih[3] | int_sb[iidx[i]].remote_global_load;
                ih[4] = ih[4] | int_sb[iidx[i]].remote_group_load;
                ih[5] = ih[5] | int_sb[iidx[i]].remote_group_amo;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (fuse[i]) begin
                fh[0] = fh[0] | float_sb[fidx[i]].fdiv_fsqrt;
                fh[1] = fh[1] | float_sb[fidx[i]].remote_dram_load;
                fh[2] = fh[2] | float_sb[fidx[i]].remote_global_load;
                fh[3] = fh[3] | float_sb[fidx[i]].remote_group_load;
            end
        end
        for (int k = 0; k < 6; k++) if (ih[k]) return 4'(k);
        for (int k = 0; k < 4; k++) if (fh[k]) return 4'(6 + k);
        return 4'd10;
    endfunction

    function automatic logic [N*W0-1:0] pack0();
        logic [N*W0-1:0] v;
        for (int k = 0; k < N; k++) v[k*W0 +: W0] = m0[k];
        return v;
    endfunction

    function automatic logic [N*W1-1:0] pack1();
        logic [N*W1-1:0] v;
        for (int k = 0; k < N; k++) v[k*W1 +: W1] = m1[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m0[k] = '0;
            m1[k] = '0;
        end
        m_hold = 1'b0;
        m_cat  = 4'hF;
        q0.delete();
        q1.delete();
    endtask

    task automatic clear_sb();
        for (int r = 0; r < RV32_reg_els_gp; r++) begin
            int_sb[r]   = '0;
            float_sb[r] = '0;
        end
        {read_rs1, read_rs2, read_frs1, read_frs2, read_frs3, write_rd, write_frd} = '0;
        {rs1, rs2, rs3, rd} = '0;
    endtask

    // Output checks valid while reset is held.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_v0"},     cmp_t'(valid0), cmp_t'(0));
        check({tag, "_rdy0"},   cmp_t'(ready0), cmp_t'(1));
        check({tag, "_cat0"},   cmp_t'(cat0),   cmp_t'(4'hF));
        check({tag, "_data0"},  cmp_t'(data0),  cmp_t'(0));
        check({tag, "_v1"},     cmp_t'(valid1), cmp_t'(0));
        check({tag, "_cat1"},   cmp_t'(cat1),   cmp_t'(4'hF));
    endtask

    // One clock: predict from current inputs, advance model at the edge,
    // then compare DUT outputs 1 time unit later.
    task automatic step();
        logic       en, acc, inc;
        logic [3:0] c;
        en  = stall_depend && !stall_all;
        c   = ref_cat();
        acc = !m_hold && snap_v;
        @(posedge clk);
        if (acc) begin
            q0.push_back(pack0());
            q1.push_back(pack1());
        end else if (m_hold && snap_yumi && q0.size() > 0) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        for (int k = 0; k < N; k++) begin
            inc = en && (c == 4'(k));
            if (acc)                            m0[k] = inc ? 32'd1 : 32'd0;
            else if (inc && m0[k] != '1)        m0[k] = m0[k] + 32'd1;
            if (inc && m1[k] != '1)             m1[k] = m1[k] + 4'd1;
        end
        if (acc)                        m_hold = 1'b1;
        else if (m_hold && snap_yumi)   m_hold = 1'b0;
        m_cat = c;
        #1;
        check("cur_cat0", cmp_t'(cat0),   cmp_t'(m_cat));
        check("cur_cat1", cmp_t'(cat1),   cmp_t'(m_cat));
        check("snap_v",   cmp_t'(valid0), cmp_t'(m_hold));
        check("snap_rdy", cmp_t'(ready0), cmp_t'(!m_hold));
        check("snap_v1",  cmp_t'(valid1), cmp_t'(m_hold));
        if (m_hold && q0.size() > 0) begin
            check("snap_data0", cmp_t'(data0), cmp_t'(q0[0]));
            check("snap_data1", cmp_t'(data1), cmp_t'(q1[0]));
        end
    endtask

    // Request a snapshot, hold it for 'delay' cycles (optionally re-requesting
    // during HOLD), then yumi it. last0/last1 record what was presented.
    task automatic do_snap(input int delay, input bit extra_req);
        snap_v = 1'b1;
        step();
        snap_v = 1'b0;
        last0 = data0;
        last1 = data1;
        for (int i = 0; i < delay; i++) begin
            snap_v = extra_req && (i == 1);
            step();
        end
        snap_v    = 1'b0;
        snap_yumi = 1'b1;
        step();
        snap_yumi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        stall_depend = 1'b0;
        stall_all    = 1'b0;
        snap_v       = 1'b0;
        snap_yumi    = 1'b0;
        clear_sb();
        reset_i = 1'b1;
        model_reset();
        #2;
        check_reset_outputs("reset");
        #20;
        reset_i = 1'b0;

        // Idle after reset: nothing counted.
        repeat (100) step();
        do_snap(0, 1'b0);
        check("idle_all0", cmp_t'(last0), cmp_t'(0));

        // idiv outranks float DRAM load on the same register.
        int_sb[5].idiv = 1'b1;
        float_sb[5].remote_dram_load = 1'b1;
        rs1 = 5'd5; read_rs1 = 1'b1; read_frs1 = 1'b1;
        stall_depend = 1'b1;
        repeat (7) step();
        stall_depend = 1'b0;
        do_snap(1, 1'b0);
        check("idiv_7",     cmp_t'(last0[0*W0 +: W0]), cmp_t'(7));
        check("f_dram_0",   cmp_t'(last0[7*W0 +: W0]), cmp_t'(0));

        // x0 hits ignored -> OTHER; stall_all suppresses counting.
        clear_sb();
        int_sb[0].remote_group_load = 1'b1;
        rs1 = 5'd0; read_rs1 = 1'b1;
        stall_depend = 1'b1;
        repeat (3) step();
        stall_all = 1'b1;
        repeat (3) step();
        stall_all = 1'b0;
        stall_depend = 1'b0;
        do_snap(0, 1'b0);
        check("other_3",    cmp_t'(last0[10*W0 +: W0]), cmp_t'(3));
        check("grp_ld_0",   cmp_t'(last0[4*W0 +: W0]),  cmp_t'(0));
        check("idiv_clr",   cmp_t'(last0[0*W0 +: W0]),  cmp_t'(0));
        check("noclr_idiv", cmp_t'(last1[0*W1 +: W1]),  cmp_t'(7));

        // Saturation boundary on the 4-bit non-clearing instance: 14, then 15.
        clear_sb();
        int_sb[5].idiv = 1'b1;
        rs1 = 5'd5; read_rs1 = 1'b1;
        stall_depend = 1'b1;
        repeat (7) step();
        stall_depend = 1'b0;
        do_snap(0, 1'b0);
        check("sat_pre_E",  cmp_t'(last1[0*W1 +: W1]), cmp_t'(4'hE));
        check("idiv32_7",   cmp_t'(last0[0*W0 +: W0]), cmp_t'(7));
        stall_depend = 1'b1;
        repeat (3) step();
        stall_depend = 1'b0;
        do_snap(0, 1'b0);
        check("sat_F",      cmp_t'(last1[0*W1 +: W1]), cmp_t'(4'hF));
        check("idiv32_3",   cmp_t'(last0[0*W0 +: W0]), cmp_t'(3));

        // Capture in a counting cycle: snapshot excludes it, live restarts at 1.
        clear_sb();
        int_sb[7].remote_global_load = 1'b1;
        rs2 = 5'd7; read_rs2 = 1'b1;
        stall_depend = 1'b1;
        repeat (9) step();
        snap_v = 1'b1;
        step();
        snap_v = 1'b0;
        stall_depend = 1'b0;
        last0 = data0;
        snap_yumi = 1'b1;
        step();
        snap_yumi = 1'b0;
        check("glob_snap9", cmp_t'(last0[3*W0 +: W0]), cmp_t'(9));
        do_snap(0, 1'b0);
        check("glob_live1", cmp_t'(last0[3*W0 +: W0]), cmp_t'(1));

        // Delayed yumi with a second request in HOLD; float WAW counts in HOLD.
        clear_sb();
        float_sb[3].fdiv_fsqrt = 1'b1;
        rd = 5'd3; write_frd = 1'b1;
        stall_depend = 1'b1;
        do_snap(5, 1'b1);
        stall_depend = 1'b0;
        check("fdiv_snap0", cmp_t'(last0[6*W0 +: W0]), cmp_t'(0));
        step();
        do_snap(0, 1'b0);
        check("fdiv_7",     cmp_t'(last0[6*W0 +: W0]), cmp_t'(7));

        // Reset while a snapshot is held drops it immediately.
        snap_v = 1'b1;
        step();
        snap_v = 1'b0;
        step();
        #2;
        reset_i = 1'b1;
        #1;
        check_reset_outputs("midhold_rst");
        model_reset();
        #1;
        reset_i = 1'b0;

        // Random traffic against the model.
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc % 8 == 0) begin
                for (int r = 0; r < RV32_reg_els_gp; r++) begin
                    int_sb[r]   = ($urandom_range(0, 2) == 0) ? vanilla_isb_info_s'(6'($urandom)) : '0;
                    float_sb[r] = ($urandom_range(0, 2) == 0) ? vanilla_fsb_info_s'(4'($urandom)) : '0;
                end
            end
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rs3 = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            {read_rs1, read_rs2, read_frs1, read_frs2, read_frs3, write_rd, write_frd} = 7'($urandom);
            stall_depend = ($urandom_range(0, 9) < 7);
            stall_all    = ($urandom_range(0, 9) == 0);
            snap_v       = ($urandom_range(0, 9) == 0);
            snap_yumi    = ($urandom_range(0, 9) < 3);
            step();
        end
        stall_depend = 1'b0;
        snap_v = 1'b0;
        snap_yumi = 1'b1;
        step();
        snap_yumi = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
